// File: rtl/ap_ctrl_txn_recorder.sv
// ap_ctrl_txn_recorder: pairs ap_ctrl_hs start/done handshakes and streams per-transaction timing records.
// Optional macro APCTRL_REC_STALL_EN adds a pre-accept stall count to every record (rec_stall).
module ap_ctrl_txn_recorder #(
   parameter int CNT_W     = 32,
   parameter int ID_W      = 16,
   parameter int MAX_OUTST = 4,
   parameter int REC_DEPTH = 8
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         ap_start,
   input  logic                         ap_ready,
   input  logic                         ap_done,
   input  logic                         ap_continue,
   input  logic                         finish,
   output logic                         rec_valid,
   input  logic                         rec_ready,
   output logic [ID_W-1:0]              rec_id,
   output logic [CNT_W-1:0]             rec_start,
   output logic [CNT_W-1:0]             rec_latency,
   output logic [CNT_W-1:0]             rec_interval,
   output logic [CNT_W-1:0]             rec_stall,
   output logic [$clog2(MAX_OUTST):0]   outstanding,
   output logic                         err_orphan_done,
   output logic                         err_outst_ovf,
   output logic [CNT_W-1:0]             rec_drop_cnt,
   output logic                         flush_done
);
   localparam int QA = $clog2(MAX_OUTST);
   localparam int RA = $clog2(REC_DEPTH);
   localparam int RW = ID_W + 3 * CNT_W;

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;
   state_t state, state_nx;

   logic [CNT_W-1:0] cycle_cnt, last_start, iv_now, r_ts, r_iv, r_lat;
   logic             have_start;
   logic [CNT_W-1:0] q_ts [MAX_OUTST];
   logic [CNT_W-1:0] q_iv [MAX_OUTST];
   logic [QA-1:0]    q_rd, q_wr;
   logic [QA:0]      q_cnt;
   logic [ID_W-1:0]  next_id;
   logic [RW-1:0]    f_mem [REC_DEPTH];
   logic [RA-1:0]    f_rd, f_wr;
   logic [RA:0]      f_cnt;
   logic live, st, dn, q_empty, q_full, bypass, push, pop, orphan, ovf, gen, f_full, f_wen, f_ren;

   always_comb begin
      live     = (state == IDLE) || (state == ACTIVE);
      st       = live & ap_start & ap_ready;
      dn       = live & ap_done & ap_continue;
      q_empty  = q_cnt == '0;
      q_full   = q_cnt == (QA+1)'(MAX_OUTST);
      bypass   = st & dn & q_empty;
      push     = st & ~bypass & (dn | ~q_full);
      pop      = dn & ~q_empty;
      orphan   = dn & ~st & q_empty;
      ovf      = st & ~dn & q_full;
      gen      = bypass | pop;
      iv_now   = have_start ? cycle_cnt - last_start : '0;
      r_ts     = bypass ? cycle_cnt : q_ts[q_rd];
      r_iv     = bypass ? iv_now : q_iv[q_rd];
      r_lat    = cycle_cnt - r_ts;
      f_full   = f_cnt == (RA+1)'(REC_DEPTH);
      f_wen    = gen & ~f_full;
      f_ren    = rec_valid & rec_ready;
      state_nx = (live & finish) ? FLUSH :
                 (state == IDLE && st) ? ACTIVE :
                 (state == FLUSH && f_cnt == '0) ? DONE : state;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state           <= IDLE;
         cycle_cnt       <= '0;
         last_start      <= '0;
         have_start      <= 1'b0;
         q_rd            <= '0;
         q_wr            <= '0;
         q_cnt           <= '0;
         next_id         <= '0;
         f_rd            <= '0;
         f_wr            <= '0;
         f_cnt           <= '0;
         rec_drop_cnt    <= '0;
         err_orphan_done <= 1'b0;
         err_outst_ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state != DONE && ~&cycle_cnt) cycle_cnt <= cycle_cnt + 1'b1;
         if (push | bypass) begin
            last_start <= cycle_cnt;
            have_start <= 1'b1;
         end
         if (push) q_wr <= q_wr + 1'b1;
         if (pop) q_rd <= q_rd + 1'b1;
         q_cnt <= (push & ~pop) ? q_cnt + 1'b1 : (pop & ~push) ? q_cnt - 1'b1 : q_cnt;
         if (gen) next_id <= next_id + 1'b1;
         if (f_wen) f_wr <= f_wr + 1'b1;
         if (f_ren) f_rd <= f_rd + 1'b1;
         f_cnt <= (f_wen & ~f_ren) ? f_cnt + 1'b1 : (f_ren & ~f_wen) ? f_cnt - 1'b1 : f_cnt;
         if (gen & f_full & ~&rec_drop_cnt) rec_drop_cnt <= rec_drop_cnt + 1'b1;
         if (orphan) err_orphan_done <= 1'b1;
         if (ovf) err_outst_ovf <= 1'b1;
      end
   end

   // storage arrays are never read while empty, so they carry no reset
   always_ff @(posedge ap_clk) begin
      if (push) begin
         q_ts[q_wr] <= cycle_cnt;
         q_iv[q_wr] <= iv_now;
      end
      if (f_wen) f_mem[f_wr] <= {next_id, r_ts, r_lat, r_iv};
   end

   assign rec_valid   = f_cnt != '0;
   assign outstanding = q_cnt;
   assign flush_done  = state == DONE;
   assign {rec_id, rec_start, rec_latency, rec_interval} = rec_valid ? f_mem[f_rd] : '0;

`ifdef APCTRL_REC_STALL_EN
   logic [CNT_W-1:0] stall_cnt, r_st;
   logic [CNT_W-1:0] q_st [MAX_OUTST];
   logic [CNT_W-1:0] s_mem [REC_DEPTH];

   assign r_st = bypass ? stall_cnt : q_st[q_rd];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) stall_cnt <= '0;
      else if (st) stall_cnt <= '0;
      else if (live & ap_start & ~ap_ready) stall_cnt <= stall_cnt + 1'b1;
   end

   always_ff @(posedge ap_clk) begin
      if (push) q_st[q_wr] <= stall_cnt;
      if (f_wen) s_mem[f_wr] <= r_st;
   end

   assign rec_stall = rec_valid ? s_mem[f_rd] : '0;
`else
   assign rec_stall = '0;
`endif
endmodule
